// File: rtl/my_fetch16_if.sv
// Bus between the fetch/issue unit and its surroundings: program-load port,
// start/stop control, the IR valid/ready handshake and status outputs.
interface my_fetch16_if #(
    parameter int ADDR_W = 4
);
    logic              pwEn;
    logic [ADDR_W-1:0] pwAddr;
    logic [15:0]       pwData;
    logic              start;
    logic              stop;
    logic [15:0]       ir;
    logic              irValid;
    logic              irReady;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic [15:0]       issueCnt;

    // Driver side: loads the program, controls execution, consumes IR
    modport master (
        output pwEn, pwAddr, pwData, start, stop, irReady,
        input  ir, irValid, pc, busy, halted, issueCnt
    );

    // Fetch unit side
    modport slave (
        input  pwEn, pwAddr, pwData, start, stop, irReady,
        output ir, irValid, pc, busy, halted, issueCnt
    );
endinterface

// File: rtl/my_fetch16.sv
// Instruction fetch/issue unit: small loadable program memory plus a PC,
// sequencing words onto IR under valid/ready. HALT (F0xx) and JMP (F1xx)
// are executed internally; other Fxxx words act as one-cycle NOPs.
module my_fetch16 #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    my_fetch16_if.slave   fetch_if
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       mem [PROG_DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              irValid_q, irValid_d;
    logic [15:0]       issueCnt_q, issueCnt_d;

    logic              idleLike;
    logic              progWrite;
    logic [15:0]       fetchWord;

    assign idleLike  = (state_q == IDLE) || (state_q == DONE);
    assign progWrite = fetch_if.pwEn && idleLike;
    assign fetchWord = mem[pc_q];

    // Program memory write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (progWrite) begin
            mem[fetch_if.pwAddr] <= fetch_if.pwData;
        end
    end

    // State, PC, instruction register and issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            irValid_q  <= 1'b0;
            issueCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            irValid_q  <= irValid_d;
            issueCnt_q <= issueCnt_d;
        end
    end

    // Next-state logic: STOP dominates, then per-state sequencing
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        irValid_d  = irValid_q;
        issueCnt_d = issueCnt_q;

        if (fetch_if.stop) begin
            state_d   = IDLE;
            irValid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (fetch_if.start) begin
                        state_d    = FETCH;
                        pc_d       = '0;
                        issueCnt_d = '0;
                    end
                end
                FETCH: begin
                    ir_d      = fetchWord;
                    irValid_d = (fetchWord[15:12] != 4'hF);
                    state_d   = ISSUE;
                end
                ISSUE: begin
                    if (ir_q[15:12] != 4'hF) begin
                        if (fetch_if.irReady) begin
                            irValid_d = 1'b0;
                            pc_d      = pc_q + ADDR_W'(1);
                            state_d   = FETCH;
                            if (issueCnt_q != 16'hFFFF) begin
                                issueCnt_d = issueCnt_q + 16'd1;
                            end
                        end
                    end else if (ir_q[11:8] == 4'h0) begin
                        state_d = DONE;
                    end else if (ir_q[11:8] == 4'h1) begin
                        pc_d    = ir_q[ADDR_W-1:0];
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign fetch_if.ir       = ir_q;
    assign fetch_if.irValid  = irValid_q;
    assign fetch_if.pc       = pc_q;
    assign fetch_if.busy     = (state_q == FETCH) || (state_q == ISSUE);
    assign fetch_if.halted   = (state_q == DONE);
    assign fetch_if.issueCnt = issueCnt_q;

endmodule

// File: tb/tb_my_fetch16.sv
// Scoreboard bench for my_fetch16: a program-level reference model predicts
// the sequence of issued words, a monitor pops and compares on each transfer.
`timescale 1ns/1ps
module tb_my_fetch16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 10 ns clock; posedges at 5, 15, ...
    always #5 clk = ~clk;

    my_fetch16_if #(.ADDR_W(4)) bus ();

    my_fetch16 #(.PROG_DEPTH(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_if (bus.slave)
    );

    typedef struct packed {
        logic [15:0] word;
        logic [3:0]  pc;
    } issue_t;

    issue_t      expQ[$];
    issue_t      monItem;
    logic [15:0] refMem [16];
    int          compared = 0;
    int          mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Program-level model: walk the program by its instruction rules and
    // queue every word that should be handed downstream
    task automatic modelRun(input int maxIssues, output int nIss, output int endPc, output bit halts);
        int pc;
        logic [15:0] w;
        pc = 0;
        nIss = 0;
        halts = 1'b0;
        for (int step = 0; step < 2000 && !halts && nIss < maxIssues; step++) begin
            w = refMem[pc];
            if (w[15:12] != 4'hF) begin
                expQ.push_back('{word: w, pc: 4'(pc)});
                nIss++;
                pc = (pc + 1) % 16;
            end else if (w[15:8] == 8'hF0) begin
                halts = 1'b1;
            end else if (w[15:8] == 8'hF1) begin
                pc = int'(w[3:0]);
            end else begin
                pc = (pc + 1) % 16;
            end
        end
        endPc = pc;
    endtask

    function automatic logic pickReady(input int mode);
        if (mode == 1) return ($urandom_range(0, 1) != 0);
        if (mode == 2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic writeWord(input int addr, input logic [15:0] data);
        @(negedge clk);
        bus.pwEn   = 1'b1;
        bus.pwAddr = 4'(addr);
        bus.pwData = data;
        @(negedge clk);
        bus.pwEn   = 1'b0;
        refMem[addr] = data;
    endtask

    // Start a run from address 0 and drive IR_READY until the model's
    // issue sequence is consumed (HALT reached, or STOP after maxIssues).
    // readyMode: 0 tied high, 1 random, 2 hold low for 5 cycles at first issue.
    task automatic applyStimulus(input string tag, input int readyMode, input int maxIssues,
                                 input bit write0, input logic [15:0] w0);
        int nIss;
        int endPc;
        bit halts;
        int stallLeft;
        bit seenValid;
        bit finished;
        stallLeft = 5;
        seenValid = 1'b0;
        finished  = 1'b0;
        if (write0) refMem[0] = w0;
        expQ.delete();
        modelRun(maxIssues, nIss, endPc, halts);

        @(negedge clk);
        bus.start   = 1'b1;
        bus.pwEn    = write0;
        bus.pwAddr  = 4'd0;
        bus.pwData  = w0;
        bus.irReady = pickReady(readyMode);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.pwEn    = 1'b0;
        bus.irReady = pickReady(readyMode);
        #1;
        checkOutput({tag, "_fetch_busy"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_fetch_valid_low"}, 32'(bus.irValid), 32'd0);
        checkOutput({tag, "_fetch_halted_low"}, 32'(bus.halted), 32'd0);
        checkOutput({tag, "_fetch_pc"}, 32'(bus.pc), 32'd0);
        checkOutput({tag, "_fetch_cnt"}, 32'(bus.issueCnt), 32'd0);
        @(negedge clk);
        bus.irReady = pickReady(readyMode);
        #1;
        checkOutput({tag, "_first_valid"}, 32'(bus.irValid), 32'(refMem[0][15:12] != 4'hF));
        if (refMem[0][15:12] != 4'hF) checkOutput({tag, "_first_ir"}, 32'(bus.ir), 32'(refMem[0]));

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            if (halts ? bus.halted : (expQ.size() == 0)) begin
                finished    = 1'b1;
                bus.irReady = 1'b0;
            end else if (readyMode == 2 && stallLeft > 0) begin
                bus.irReady = 1'b0;
                #1;
                if ((bus.irValid || seenValid) && expQ.size() > 0) begin
                    seenValid = 1'b1;
                    stallLeft--;
                    checkOutput({tag, "_stall_valid"}, 32'(bus.irValid), 32'd1);
                    checkOutput({tag, "_stall_ir"}, 32'(bus.ir), 32'(expQ[0].word));
                    checkOutput({tag, "_stall_cnt"}, 32'(bus.issueCnt), 32'd0);
                end
            end else begin
                bus.irReady = pickReady(readyMode == 1 ? 1 : 0);
            end
        end
        checkOutput({tag, "_finished"}, 32'(finished), 32'd1);

        if (!halts) begin
            bus.stop = 1'b1;
            @(negedge clk);
            bus.stop = 1'b0;
            #1;
            checkOutput({tag, "_stop_busy"}, 32'(bus.busy), 32'd0);
            checkOutput({tag, "_stop_valid"}, 32'(bus.irValid), 32'd0);
        end
        #1;
        checkOutput({tag, "_halted"}, 32'(bus.halted), 32'(halts));
        checkOutput({tag, "_cnt"}, 32'(bus.issueCnt), 32'(nIss));
        checkOutput({tag, "_pc"}, 32'(bus.pc), 32'(endPc));
        checkOutput({tag, "_queue_empty"}, 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: looks just after the falling edge, where valid/ready already
    // hold the values the next rising edge will see
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.irValid) begin
            checkOutput("valid_not_control", 32'(bus.ir[15:12] == 4'hF), 32'd0);
            if (bus.irReady && !bus.stop) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_issue: got ir %0h pc %0h, expected no transfer", bus.ir, bus.pc);
                end else begin
                    monItem = expQ.pop_front();
                    checkOutput("issue_ir", 32'(bus.ir), 32'(monItem.word));
                    checkOutput("issue_pc", 32'(bus.pc), 32'(monItem.pc));
                end
            end
        end
    end

    // Hard bound on total run time
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nIss;
        int endPc;
        bit halts;
        bit gotValid;
        logic [15:0] w;
        logic [15:0] r;
        int tgt;
        int kind;

        bus.pwEn    = 1'b0;
        bus.pwAddr  = '0;
        bus.pwData  = '0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irReady = 1'b0;

        // Reset values
        #12;
        checkOutput("reset_ir", 32'(bus.ir), 32'd0);
        checkOutput("reset_valid", 32'(bus.irValid), 32'd0);
        checkOutput("reset_pc", 32'(bus.pc), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_halted", 32'(bus.halted), 32'd0);
        checkOutput("reset_cnt", 32'(bus.issueCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic issue
        writeWord(0, 16'h00A1);
        writeWord(1, 16'h0021);
        writeWord(2, 16'hF000);
        applyStimulus("basic", 0, 1000, 1'b0, 16'h0);
        checkOutput("basic_cnt_is_2", 32'(bus.issueCnt), 32'd2);
        checkOutput("basic_pc_is_2", 32'(bus.pc), 32'd2);

        // Backpressure at the first issue
        applyStimulus("backpressure", 2, 1000, 1'b0, 16'h0);

        // JMP
        writeWord(0, 16'h00C1);
        writeWord(1, 16'hF103);
        writeWord(3, 16'h00E1);
        writeWord(4, 16'hF000);
        applyStimulus("jmp", 1, 1000, 1'b0, 16'h0);
        checkOutput("jmp_pc_is_4", 32'(bus.pc), 32'd4);
        checkOutput("jmp_cnt_is_2", 32'(bus.issueCnt), 32'd2);

        // Wrap-around
        for (int i = 0; i < 16; i++) writeWord(i, 16'h0001);
        writeWord(1, 16'hF000);
        applyStimulus("wrap_halt", 0, 1000, 1'b0, 16'h0);
        checkOutput("wrap_halt_pc_is_1", 32'(bus.pc), 32'd1);
        writeWord(1, 16'h0001);
        writeWord(15, 16'h0001);
        applyStimulus("wrap_run", 1, 20, 1'b0, 16'h0);
        checkOutput("wrap_cnt_is_20", 32'(bus.issueCnt), 32'd20);

        // STOP mid-handshake plus a write attempted while busy
        @(negedge clk);
        bus.start   = 1'b1;
        bus.irReady = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        gotValid  = 1'b0;
        for (int cyc = 0; cyc < 10 && !gotValid; cyc++) begin
            @(negedge clk);
            #1;
            gotValid = bus.irValid;
        end
        checkOutput("stop_reached_issue", 32'(gotValid), 32'd1);
        bus.pwEn   = 1'b1;
        bus.pwAddr = 4'd5;
        bus.pwData = 16'hBEEF;
        bus.stop   = 1'b1;
        @(negedge clk);
        bus.pwEn = 1'b0;
        bus.stop = 1'b0;
        #1;
        checkOutput("stop_valid", 32'(bus.irValid), 32'd0);
        checkOutput("stop_busy", 32'(bus.busy), 32'd0);
        checkOutput("stop_ir_held", 32'(bus.ir), 32'h0001);
        checkOutput("stop_pc_held", 32'(bus.pc), 32'd0);
        checkOutput("stop_cnt_held", 32'(bus.issueCnt), 32'd0);
        writeWord(6, 16'hF000);
        applyStimulus("after_stop", 0, 1000, 1'b0, 16'h0);

        // Async reset in the middle of ISSUE
        expQ.delete();
        modelRun(3, nIss, endPc, halts);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.irReady = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        gotValid  = 1'b0;
        for (int cyc = 0; cyc < 40 && !gotValid; cyc++) begin
            @(negedge clk);
            bus.irReady = (expQ.size() != 0);
            if (expQ.size() == 0 && bus.irValid) gotValid = 1'b1;
        end
        checkOutput("areset_reached_issue", 32'(gotValid), 32'd1);
        checkOutput("areset_pre_cnt", 32'(bus.issueCnt), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_ir", 32'(bus.ir), 32'd0);
        checkOutput("areset_valid", 32'(bus.irValid), 32'd0);
        checkOutput("areset_pc", 32'(bus.pc), 32'd0);
        checkOutput("areset_busy", 32'(bus.busy), 32'd0);
        checkOutput("areset_halted", 32'(bus.halted), 32'd0);
        checkOutput("areset_cnt", 32'(bus.issueCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random programs: ordinary words, NOPs, forward JMPs, HALT at the end;
        // word 0 is written in the same cycle as START
        for (int run = 0; run < 4; run++) begin
            for (int a = 1; a < 15; a++) begin
                kind = $urandom_range(0, 9);
                r = 16'($urandom);
                if (kind == 7) begin
                    w = {4'hF, 4'(2 + $urandom_range(0, 13)), r[7:0]};
                end else if (kind >= 8) begin
                    tgt = $urandom_range(a + 1, 15);
                    w = {8'hF1, r[7:4], 4'(tgt)};
                end else begin
                    w = r;
                    if (w[15:12] == 4'hF) w[15:12] = 4'h3;
                end
                writeWord(a, w);
            end
            writeWord(15, 16'hF000);
            r = 16'($urandom);
            if (r[15:12] == 4'hF) r[15:12] = 4'h1;
            applyStimulus($sformatf("random%0d", run), 1, 1000, 1'b1, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
